systolic_drain: RTL and testbench
=================================

# systolic_drain

Output drain stage directly downstream of the systolic array controller and PE grid. Once the controller reports compute complete, the block:
- waits a fixed settle interval for in-flight partial sums to reach the accumulators;
- snapshots all size×size accumulators in one cycle;
- streams them out row-major over a val/rdy interface;
- pulses an accumulator clear, then holds done until re-armed.

## Interface
- size, 4, array dimension; results per drain = size*size
- width, 16, accumulator/result bit width
- settle, 2*size-1, cycles waited after go before capture; must be ≥1
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- drain_go  input  1  level; high when controller signals compute complete (ctrl in OUT, FIFOs empty)
- acc  input  width × [size][size]  live accumulator values, acc[r][c]
- out_msg  output  width  current result word
- out_val  output  1  out_msg valid
- out_rdy  input  1  consumer ready
- out_last  output  1  high with final word (r=c=size-1)
- acc_clr  output  1  one-cycle pulse clearing PE accumulators
- done  output  1  drain complete; held until drain_go falls

## Operation
- States: IDLE, SETTLE, SEND, DONE. Package enum, 2-bit encoding.
- IDLE:
  - drain_go=1 → SETTLE; cnt loads settle-1.
  - Otherwise stay.
- SETTLE:
  - cnt≠0: decrement.
  - cnt=0: capture snap[r][c]←acc[r][c] for all r,c; idx←0; → SEND.
  - drain_go ignored.
- SEND:
  - out_val=1; out_msg=snap[idx/size][idx%size]; out_last=(idx==size*size-1).
  - On out_val&out_rdy:
    - idx<last: idx++.
    - idx=last: → DONE, acc_clr=1 next cycle.
  - Stall (out_rdy=0): out_msg, idx, out_last held stable; out_val never drops once raised.
- DONE:
  - done=1.
  - acc_clr high only on the first DONE cycle.
  - drain_go=0 → IDLE; otherwise stay.
  - Stays at least one cycle even if drain_go is already low.
- idx width $clog2(size*size); cnt width $clog2(settle)+1. No arithmetic on data; words pass through unmodified.
- Snapshot isolates output from acc changes after capture, including acc_clr effects.

## Timing
- Reset (rst=0, async, immediate), all regardless of current state:
  - state=IDLE, cnt=0, idx=0, snap=0.
  - out_val=0, out_last=0, out_msg=0, acc_clr=0, done=0.
- Release is synchronous to the next edge. Reset mid-SEND discards remaining words; no partial done.
- Latency:
  - drain_go sampled high at edge E0 → SETTLE from E0.
  - Capture at edge E0+settle → out_val high in cycle after E0+settle.
- Throughput: one word per cycle with out_rdy held high. SEND lasts exactly size*size cycles.
- Final handshake at edge Ef → DONE; acc_clr=1 and done=1 in cycle after Ef; acc_clr=0 thereafter.
- Outputs:
  - out_val, out_last, out_msg, done: decoded from registered state/idx/snap, with no combinational path from out_rdy.
  - acc_clr: registered.
- drain_go toggling during SETTLE/SEND: no effect. drain_go low in IDLE: no activity.

## Structure
- Package systolic_pkg:
  - drain state enum typedef.
  - localparam helpers for idx/cnt widths.
- Sub-module systolic_snapshot: size×size×width register bank with single capture enable and row-major read index. Holds snap only; FSM, counters and handshake stay in systolic_drain.

## Test plan
Configuration for all scenarios: size=4, width=16, settle=7.
- Basic drain:
  - Stimulus: acc[r][c]=16*r+c; drain_go high at E0; out_rdy=1.
  - Required: out_val first high after E7; words 0,1,…,15 over 16 consecutive cycles; out_last only on 15 (acc[3][3]); acc_clr one-cycle pulse after the final handshake; done held.
- Backpressure:
  - Stimulus: out_rdy random 50% duty.
  - Required: all 16 words in order, no drops or duplicates; out_msg/out_last stable while stalled; out_val continuous from first word through last.
- Snapshot isolation:
  - Stimulus: change all acc to 0xFFFF one cycle after capture.
  - Required: streamed values still 16*r+c.
- Re-arm:
  - Stimulus: drain_go held high after done, later dropped.
  - Required: done remains 1 until drain_go=0, then IDLE.
  - Stimulus: second drain_go.
  - Required: new full 16-word drain.
- Reset mid-stream:
  - Stimulus: rst=0 asynchronously after word 5.
  - Required: all outputs 0 immediately; after release with drain_go low, no out_val; next drain restarts at word 0.
- Edge parameter:
  - Stimulus: settle=1, size=2, drain_go high at E0.
  - Required: out_val high after E1; 4 words.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic array output drain.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2,
        DONE   = 2'd3
    } drain_state_t;

    // Row-major word index width; held at 1 so a 1x1 array still has a real index.
    function automatic int idx_width(input int size);
        int w;
        w = $clog2(size * size);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_width(input int settle);
        return $clog2(settle) + 1;
    endfunction

endpackage

// File: rtl/systolic_snapshot.sv
// size x size accumulator snapshot bank: one-cycle capture of every accumulator,
// combinational row-major read of the captured words.
module systolic_snapshot
    import systolic_pkg::*;
#(
    parameter int size  = 4,
    parameter int width = 16,
    localparam int idx_w = idx_width(size)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cap,
    input  logic [size-1:0][size-1:0][width-1:0]  acc,
    input  logic [idx_w-1:0]                      idx,
    output logic [width-1:0]                      word
);

    localparam int words = size * size;

    logic [width-1:0] snap_q [words];

    genvar gi;
    generate
        for (gi = 0; gi < words; gi++) begin : g_bank
            logic [width-1:0] snap_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    snap_reg <= '0;
                end else if (cap) begin
                    snap_reg <= acc[gi / size][gi % size];
                end
            end

            assign snap_q[gi] = snap_reg;
        end
    endgenerate

    // Guard against indices past the last word when size*size is not a power of two.
    always_comb begin
        word = '0;
        if (int'(idx) < words) begin
            word = snap_q[idx];
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Output drain: waits for in-flight sums to settle, snapshots the accumulator grid,
// streams it row-major over val/rdy, then pulses acc_clr and holds done until re-armed.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int size   = 4,
    parameter int width  = 16,
    parameter int settle = 2 * size - 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  drain_go,
    input  logic [size-1:0][size-1:0][width-1:0]  acc,
    output logic [width-1:0]                      out_msg,
    output logic                                  out_val,
    input  logic                                  out_rdy,
    output logic                                  out_last,
    output logic                                  acc_clr,
    output logic                                  done
);

    localparam int idx_w = idx_width(size);
    localparam int cnt_w = cnt_width(settle);
    localparam logic [idx_w-1:0] idx_last = idx_w'(size * size - 1);
    localparam logic [cnt_w-1:0] cnt_init = cnt_w'(settle - 1);

    drain_state_t     state_reg, state_next;
    logic [cnt_w-1:0] cnt_reg, cnt_next;
    logic [idx_w-1:0] idx_reg, idx_next;
    logic             acc_clr_reg, acc_clr_next;
    logic             capture;
    logic [width-1:0] snap_word;

    systolic_snapshot #(
        .size  (size),
        .width (width)
    ) u_snapshot (
        .clk  (clk),
        .rst  (rst),
        .cap  (capture),
        .acc  (acc),
        .idx  (idx_reg),
        .word (snap_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            acc_clr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            acc_clr_reg <= acc_clr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        acc_clr_next = 1'b0;
        capture      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (drain_go) begin
                    state_next = SETTLE;
                    cnt_next   = cnt_init;
                end
            end
            SETTLE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - cnt_w'(1);
                end else begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_rdy) begin
                    if (idx_reg == idx_last) begin
                        state_next   = DONE;
                        acc_clr_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + idx_w'(1);
                    end
                end
            end
            DONE: begin
                if (!drain_go) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is decoded from registers only; out_rdy never reaches them.
    assign out_val  = (state_reg == SEND);
    assign out_last = out_val && (idx_reg == idx_last);
    assign out_msg  = out_val ? snap_word : '0;
    assign done     = (state_reg == DONE);
    assign acc_clr  = acc_clr_reg;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: 4x4/settle 7 drains plus a 2x2/settle 1 edge instance.
module tb_systolic_drain;

    logic clk = 1'b0;
    logic rst;

    logic                    go, out_rdy, out_val, out_last, acc_clr, done;
    logic [3:0][3:0][15:0]   acc;
    logic [15:0]             out_msg;

    logic                    go2, rdy2, val2, last2, clr2, done2;
    logic [1:0][1:0][15:0]   acc2;
    logic [15:0]             msg2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_drain #(.size(4), .width(16), .settle(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .drain_go (go),
        .acc      (acc),
        .out_msg  (out_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_last (out_last),
        .acc_clr  (acc_clr),
        .done     (done)
    );

    systolic_drain #(.size(2), .width(16), .settle(1)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .drain_go (go2),
        .acc      (acc2),
        .out_msg  (msg2),
        .out_val  (val2),
        .out_rdy  (rdy2),
        .out_last (last2),
        .acc_clr  (clr2),
        .done     (done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // acc[r][c] = 16*r + c, word i of a size-n drain is acc[i/n][i%n]
    function automatic logic [31:0] word_of(input int i, input int n);
        return 32'(16 * (i / n) + (i % n));
    endfunction

    task automatic fill_acc();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                acc[r][c] = 16'(16 * r + c);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                acc2[r][c] = 16'(16 * r + c);
    endtask

    task automatic drain4(input bit backpressure, input bit clobber);
        int cyc;
        int idx;
        int guard;
        bit rdy;
        @(negedge clk);
        go = 1'b1;
        out_rdy = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_val && cyc < 30);
        check("first_val_latency", 32'(cyc), 32'd8);
        if (clobber) acc = {16{16'hFFFF}};
        idx = 0;
        guard = 0;
        while (idx < 16 && guard < 200) begin
            check("val_held", {31'b0, out_val}, 32'd1);
            check("msg", {16'b0, out_msg}, word_of(idx, 4));
            check("last", {31'b0, out_last}, {31'b0, (idx == 15)});
            rdy = backpressure ? 1'($urandom_range(0, 1)) : 1'b1;
            out_rdy = rdy;
            @(negedge clk);
            guard++;
            if (rdy) begin
                $display("word %0d: 0x%04h", idx, word_of(idx, 4));
                idx++;
            end
        end
        check("words_sent", 32'(idx), 32'd16);
        check("clr_pulse", {31'b0, acc_clr}, 32'd1);
        check("done_set", {31'b0, done}, 32'd1);
        check("val_off_done", {31'b0, out_val}, 32'd0);
        out_rdy = 1'b0;
        @(negedge clk);
        check("clr_one_cycle", {31'b0, acc_clr}, 32'd0);
        check("done_hold", {31'b0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b0;
        go = 1'b0;
        out_rdy = 1'b0;
        go2 = 1'b0;
        rdy2 = 1'b0;
        fill_acc();
        #1;
        check("rst_val", {31'b0, out_val}, 32'd0);
        check("rst_msg", {16'b0, out_msg}, 32'd0);
        check("rst_last", {31'b0, out_last}, 32'd0);
        check("rst_clr", {31'b0, acc_clr}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle with drain_go low does nothing.
        repeat (3) begin
            @(negedge clk);
            check("idle_quiet", {31'b0, out_val | done}, 32'd0);
        end

        // Basic drain, then re-arm: done holds while drain_go stays high.
        drain4(1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("done_while_go", {31'b0, done}, 32'd1);
        end
        go = 1'b0;
        @(negedge clk);
        check("done_drop", {31'b0, done}, 32'd0);
        check("idle_no_val", {31'b0, out_val}, 32'd0);

        // Second drain with backpressure and accumulators overwritten after capture.
        drain4(1'b1, 1'b1);
        go = 1'b0;
        @(negedge clk);
        check("done_drop2", {31'b0, done}, 32'd0);
        fill_acc();

        // Reset in the middle of the stream.
        @(negedge clk);
        go = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_val && cyc < 30);
        check("mid_first_val", {31'b0, out_val}, 32'd1);
        out_rdy = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_word5", {16'b0, out_msg}, word_of(5, 4));
        #2 rst = 1'b0;
        #1;
        check("mid_rst_val", {31'b0, out_val}, 32'd0);
        check("mid_rst_msg", {16'b0, out_msg}, 32'd0);
        check("mid_rst_last", {31'b0, out_last}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_clr", {31'b0, acc_clr}, 32'd0);
        go = 1'b0;
        out_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_quiet", {31'b0, out_val | done | acc_clr}, 32'd0);
        end
        drain4(1'b0, 1'b0);
        go = 1'b0;
        @(negedge clk);

        // 2x2 array with settle=1.
        go2 = 1'b1;
        rdy2 = 1'b1;
        @(negedge clk);
        check("e_val_after_e0", {31'b0, val2}, 32'd0);
        @(negedge clk);
        check("e_val_after_e1", {31'b0, val2}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("e_val", {31'b0, val2}, 32'd1);
            check("e_msg", {16'b0, msg2}, word_of(i, 2));
            check("e_last", {31'b0, last2}, {31'b0, (i == 3)});
            $display("edge word %0d: 0x%04h", i, word_of(i, 2));
            @(negedge clk);
        end
        check("e_clr", {31'b0, clr2}, 32'd1);
        check("e_done", {31'b0, done2}, 32'd1);
        check("e_val_off", {31'b0, val2}, 32'd0);
        go2 = 1'b0;
        @(negedge clk);
        check("e_clr_off", {31'b0, clr2}, 32'd0);
        check("e_done_drop", {31'b0, done2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
